// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-source round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

    localparam int unsigned N_SRC = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Result of the circular priority search.
    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant/data bundle between the eight sources, the arbiter and the consumer.
interface mux8_rr_arbiter_if;
    import mux8_rr_arbiter_pkg::*;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] din;
    logic             ready;
    logic [N_SRC-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             dout;
    logic             dout_valid;
    logic             busy;

    modport master (
        output req, din, ready,
        input  gnt, sel, dout, dout_valid, busy
    );

    modport slave (
        input  req, din, ready,
        output gnt, sel, dout, dout_valid, busy
    );

endinterface

// File: rtl/mux8_rr_arbiter_sel.sv
// Combinational 8:1 single-bit select.
module mux8_sel
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);

    always_comb begin
        y = din[sel];
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the shared 8:1 mux select, with a per-grant beat limit
// and a registered data bit toward a single consumer.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mux8_rr_arbiter_if.slave   bus
);

    state_t            state, state_n;
    logic [SEL_W-1:0]  ptr, ptr_n;
    logic [SEL_W-1:0]  sel_q, sel_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [HOLD_W-1:0] hold_inc;
    logic [N_SRC-1:0]  own_mask;
    logic [N_SRC-1:0]  cand;
    logic              xfer;
    logic              at_limit;
    logic              others;
    logic              sel_bit;
    logic              dout_q;
    logic              dv_q;
    pick_t             srch;

    // First set bit of r, scanning circularly upward from start.
    function automatic pick_t rr_search(input logic [N_SRC-1:0] r,
                                        input logic [SEL_W-1:0] start);
        pick_t            res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            idx = start + SEL_W'(i);
            if (!res.found && r[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

    mux8_sel u_sel (
        .din (bus.din),
        .sel (sel_q),
        .y   (sel_bit)
    );

    always_comb begin
        own_mask = N_SRC'(1) << sel_q;
        xfer     = (state == ST_GRANT) && bus.req[sel_q] && bus.ready;
        hold_inc = hold_cnt + 1'b1;
        at_limit = xfer && (hold_inc == HOLD_W'(MAX_HOLD));
        others   = |(bus.req & ~own_mask);
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel_q;
        hold_n  = hold_cnt;
        cand    = bus.req;
        srch    = '0;
        unique case (state)
            ST_IDLE: begin
                srch = rr_search(bus.req, ptr);
                if (srch.found) begin
                    state_n = ST_GRANT;
                    sel_n   = srch.idx;
                    hold_n  = '0;
                end
            end
            ST_GRANT: begin
                if (!bus.req[sel_q] || (at_limit && others)) begin
                    // Only a beat-limit release excludes the outgoing source from the search.
                    ptr_n = sel_q + 1'b1;
                    cand  = at_limit ? (bus.req & ~own_mask) : bus.req;
                    srch  = rr_search(cand, ptr_n);
                    if (srch.found) begin
                        sel_n  = srch.idx;
                        hold_n = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (xfer) begin
                    hold_n = at_limit ? '0 : hold_inc;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel_q    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            sel_q    <= sel_n;
            hold_cnt <= hold_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 1'b0;
            dv_q   <= 1'b0;
        end else begin
            dv_q <= xfer;
            if (xfer) begin
                dout_q <= sel_bit;
            end
        end
    end

    always_comb begin
        bus.gnt        = (state == ST_GRANT) ? own_mask : '0;
        bus.sel        = sel_q;
        bus.dout       = dout_q;
        bus.dout_valid = dv_q;
        bus.busy       = (state == ST_GRANT);
    end

endmodule
